// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the RV32M multiply/divide unit.
// The core drives the request side (master); the unit drives the response side (slave).
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] Rs1_data;
    logic [31:0] Rs2_data;
    logic [4:0]  Rd;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [4:0]  Rd_out;
    logic        RegWrite_out;

    modport master (
        output start, funct3, Rs1_data, Rs2_data, Rd,
        input  busy, done, Result, Rd_out, RegWrite_out
    );

    modport slave (
        input  start, funct3, Rs1_data, Rs2_data, Rd,
        output busy, done, Result, Rd_out, RegWrite_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and a one-cycle fast path for divide corner cases.
module muldiv_unit (
    input  logic           clk,
    input  logic           reset,
    muldiv_unit_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_q, neg_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] result_q, result_d;

    logic        aSigned, bSigned, aNeg, bNeg, isDivIn, fastPath;
    logic [31:0] magA, magB, fastResult;
    logic [32:0] mulSum, divTrial;
    logic [31:0] hiStep, loStep, quo, rem, finalResult;
    logic [63:0] product;

    // Decode the incoming request: signedness, magnitudes and divide corner cases.
    always_comb begin
        aSigned  = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
        bSigned  = aSigned && (bus.funct3 != 3'b010);
        aNeg     = aSigned && bus.Rs1_data[31];
        bNeg     = bSigned && bus.Rs2_data[31];
        magA     = aNeg ? (32'd0 - bus.Rs1_data) : bus.Rs1_data;
        magB     = bNeg ? (32'd0 - bus.Rs2_data) : bus.Rs2_data;
        isDivIn  = bus.funct3[2];
        fastPath = isDivIn && ((bus.Rs2_data == 32'd0) ||
                   (!bus.funct3[0] && (bus.Rs1_data == 32'h8000_0000) &&
                    (bus.Rs2_data == 32'hFFFF_FFFF)));
        if (bus.Rs2_data == 32'd0) begin
            fastResult = bus.funct3[1] ? bus.Rs1_data : 32'hFFFF_FFFF;
        end else begin
            fastResult = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration step; hi holds the partial product / partial remainder.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        divTrial = {hi_q, lo_q[31]} - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!divTrial[32]) begin
                hiStep = divTrial[31:0];
                loStep = {lo_q[30:0], 1'b1};
            end else begin
                hiStep = {hi_q[30:0], lo_q[31]};
                loStep = {lo_q[30:0], 1'b0};
            end
        end else begin
            hiStep = mulSum[32:1];
            loStep = {mulSum[0], lo_q[31:1]};
        end

        product = {hiStep, loStep};
        if (neg_q) begin
            product = 64'd0 - product;
        end
        quo = neg_q ? (32'd0 - loStep) : loStep;
        rem = neg_q ? (32'd0 - hiStep) : hiStep;

        case (op_q)
            3'b000:         finalResult = product[31:0];
            3'b001, 3'b010,
            3'b011:         finalResult = product[63:32];
            3'b100, 3'b101: finalResult = quo;
            default:        finalResult = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.funct3;
                    rd_d   = bus.Rd;
                    // Remainder follows the dividend; product and quotient follow the sign xor.
                    neg_d  = (bus.funct3[2] && bus.funct3[1]) ? aNeg : (aNeg ^ bNeg);
                    opnd_d = isDivIn ? magB : magA;
                    hi_d   = 32'd0;
                    lo_d   = isDivIn ? magA : magB;
                    cnt_d  = 6'd0;
                    if (fastPath) begin
                        result_d = fastResult;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = hiStep;
                lo_d  = loStep;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    result_d = finalResult;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            neg_q    <= 1'b0;
            opnd_q   <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.RegWrite_out = (state_q == S_DONE) && (rd_q != 5'd0);
    assign bus.Result       = result_q;
    assign bus.Rd_out       = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs,
// a negedge monitor pops and compares them whenever done is seen.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
        int          doneCount;
    } expT;

    logic clk;
    logic reset;
    int   cycleCount;
    int   checkCount;
    int   passCount;
    expT  scoreboard[$];

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Waits for the unit to go idle, pulses start for one cycle and records the expected write-back.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] expResult,
                                 input int latency, input bit expectDone);
        int  guard;
        expT e;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (bus.busy) begin
            checkOutput("idle wait", {31'd0, bus.busy}, 32'd0);
        end
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.Rs1_data = a;
        bus.Rs2_data = b;
        bus.Rd       = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("accept busy", {31'd0, bus.busy}, 32'd1);
        if (expectDone) begin
            e.result    = expResult;
            e.rd        = rd;
            e.regWrite  = (rd != 5'd0);
            e.doneCount = cycleCount + latency - 1;
            scoreboard.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected done", {31'd0, bus.done}, 32'd0);
            end else begin
                expT e;
                e = scoreboard.pop_front();
                checkOutput("Result", bus.Result, e.result);
                checkOutput("Rd_out", {27'd0, bus.Rd_out}, {27'd0, e.rd});
                checkOutput("RegWrite_out", {31'd0, bus.RegWrite_out}, {31'd0, e.regWrite});
                checkOutput("done cycle", cycleCount, e.doneCount);
                checkOutput("busy at done", {31'd0, bus.busy}, 32'd1);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, bus.done}, 32'd0);
        checkOutput({tag, " RegWrite_out"}, {31'd0, bus.RegWrite_out}, 32'd0);
        checkOutput({tag, " Result"}, bus.Result, 32'd0);
        checkOutput({tag, " Rd_out"}, {27'd0, bus.Rd_out}, 32'd0);
    endtask

    initial begin
        int guard;
        cycleCount   = 0;
        checkCount   = 0;
        passCount    = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = 3'd0;
        bus.Rs1_data = 32'd0;
        bus.Rs2_data = 32'd0;
        bus.Rd       = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        $display("[TB] MUL 7*6 with busy window");
        applyStimulus(3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 33, 1'b1);
        for (int i = 1; i <= 34; i++) begin
            checkOutput($sformatf("busy cycle %0d", i), {31'd0, bus.busy}, {31'd0, (i <= 33)});
            if (i < 34) begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] high-half multiplies of 0xFFFFFFFF");
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 33, 1'b1);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 33, 1'b1);
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 33, 1'b1);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 33, 1'b1);

        $display("[TB] divide -7 by 2");
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, 1'b1);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 1'b1);
        applyStimulus(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 33, 1'b1);
        applyStimulus(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h0000_0001, 33, 1'b1);

        $display("[TB] fast-path corner cases");
        applyStimulus(3'b101, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1, 1'b1);
        applyStimulus(3'b111, 32'd5, 32'd0, 5'd7, 32'd5, 1, 1'b1);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, 1'b1);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1, 1'b1);

        $display("[TB] start ignored while busy");
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.funct3   = 3'b000;
        bus.Rs1_data = 32'd3;
        bus.Rs2_data = 32'd3;
        bus.Rd       = 5'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        $display("[TB] Rd=0 suppresses RegWrite_out");
        applyStimulus(3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 33, 1'b1);

        $display("[TB] reset in the middle of a divide");
        applyStimulus(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd11, 32'd0, 33, 1'b0);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("mid-op reset");
        applyStimulus(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd12, 32'hFFFF_FFF2, 33, 1'b1);

        guard = 0;
        while (scoreboard.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        checkOutput("pending results", scoreboard.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It takes the two source operands read from the register file, computes one of the eight M-extension operations over multiple cycles, and returns a 32-bit result plus the destination register index for write-back into the register file. While it computes, it asserts `busy` so the core holds its PC and suppresses other writes.

## Interface

Parameters: none.

Ports:

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `start` in 1: request; accepted only in IDLE.
- `funct3` in 3: operation. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Rs1_data` in 32: operand A (dividend / multiplicand).
- `Rs2_data` in 32: operand B (divisor / multiplier).
- `Rd` in 5: destination index; captured on accept.
- `busy` out 1: high from the cycle after accept through the DONE cycle inclusive.
- `done` out 1: one-cycle pulse; `Result` and `Rd_out` are valid in that cycle.
- `Result` out 32: registered result; holds its value until the next `done`.
- `Rd_out` out 5: captured `Rd`; holds until the next accept.
- `RegWrite_out` out 1: equals `done`. It is forced to 0 when `Rd_out` is 0.

## Operation

- States: IDLE, CALC, DONE.
- IDLE → CALC on `start`, or IDLE → DONE on `start` with a fast-path case. On accept the block latches `funct3`, `Rd`, the operand magnitudes, and the result sign flags.
- CALC: 32 iterations, one per cycle, with a 6-bit counter running 0..31. Counter value 31 → DONE.
- DONE: for one cycle `done`=1 and `busy`=1, then → IDLE.
- `start` in CALC or DONE is ignored. There is no queueing and no latch update.
- Multiply:
  - Unsigned shift-add on magnitudes produces a 64-bit product.
  - The product is two's-complement negated when the operand signs differ.
  - Signedness: MUL/MULH treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU treats both as unsigned.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring shift-subtract on magnitudes.
  - Quotient is negated when sign(A) xor sign(B) and the operation is signed.
  - Remainder takes the sign of A when the operation is signed.
- Fast path (no CALC):
  - B=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → A.
  - DIV with A=0x80000000 and B=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Reset in any state: next state is IDLE. `busy`, `done`, `RegWrite_out`, `Result` and `Rd_out` all become 0. An in-flight operation is discarded and produces no `done`.

## Timing

- Accept edge = cycle 0. This is the edge where IDLE and `start`=1 are sampled.
- Normal op: `busy`=1 during cycles 1..33, CALC occupies cycles 1..32, and `done`=1 in cycle 33. Latency is 33 cycles.
- Fast path: DONE in cycle 1, with `busy`=1 and `done`=1 in cycle 1 only. Latency is 1 cycle.
- Earliest next accept: the cycle after DONE (cycle 34, or cycle 2 for the fast path).
- Operands are sampled only at accept. Changes to inputs during CALC have no effect.
- Reset values of all outputs are 0.
- `done` and `RegWrite_out` are registered outputs, not combinational from `start`.

## Test plan

- MUL: A=7, B=6, Rd=5 → `done` in cycle 33, `Result`=42, `Rd_out`=5, `RegWrite_out`=1, and `busy` high for cycles 1..33.
- MULH/MULHSU/MULHU: A=B=0xFFFFFFFF.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE.
  - MUL → 0x00000001.
- DIV/REM: A=0xFFFFFFF9 (-7), B=2.
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF, with `done` in cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 in cycle 1.
  - REM with the same operands → 0.
- Contention: second `start` with different operands in cycle 10 → ignored; the first result is returned in cycle 33. Rd=0 → `done`=1 and `RegWrite_out`=0.
- Reset in cycle 15 of a DIV → cycle 16 shows all outputs 0 and IDLE, with no `done` ever. A new `start` in cycle 16 is accepted normally.
